mar_burst: RTL and testbench

Parametrised memory address register with burst sequencing for the 8-bit CPU model. Loads the address from the PC or the data bus, or increments it in place. On `start` it drives a req/ack memory handshake and steps the address through a burst of up to 2^BLW beats. It sits between the PC/data bus and the memory, replacing the fixed 6-bit MAR in designs that need wider addresses or block transfers.

---
 rtl/mar_burst.sv | 196 +++++++++++++++++++
 tb/tb_mar_burst.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mar_burst.sv
// mar_burst -- memory address register with burst sequencing.
//
// Holds the memory address for the 8-bit CPU model. In IDLE the address can
// be loaded from the PC or the data bus, or incremented in place. A start
// request runs a req/ack handshake with memory and steps the address through
// a burst of burst_len+1 beats.
//
// Optional feature: define MAR_TIMEOUT_EN to abort a burst when memory does
// not acknowledge within TIMEOUT consecutive cycles. Without it, err is tied
// low and ACCESS waits indefinitely.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ld_pc      load addr from pc_in
//   ld_bus     load addr from bus_in (wins over ld_pc and inc)
//   inc        increment addr modulo 2^AW
//   pc_in      address from the PC
//   bus_in     address from the data bus (truncated or zero-extended to AW)
//   start      begin a burst at the current (or same-cycle loaded) address
//   burst_len  beats minus one, sampled with start
//   mem_ack    memory accepted the current beat
//   addr       registered address to memory
//   mem_req    registered access request
//   busy       high whenever the sequencer is not IDLE
//   done       one-cycle pulse after the final beat
//   wrap       one-cycle pulse after addr wraps from all-ones to zero
//   err        one-cycle pulse on timeout abort (always 0 without the macro)

module mar_burst #(
    parameter int AW      = 6,
    parameter int DW      = 8,
    parameter int BLW     = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_pc,
    input  logic           ld_bus,
    input  logic           inc,
    input  logic [AW-1:0]  pc_in,
    input  logic [DW-1:0]  bus_in,
    input  logic           start,
    input  logic [BLW-1:0] burst_len,
    input  logic           mem_ack,
    output logic [AW-1:0]  addr,
    output logic           mem_req,
    output logic           busy,
    output logic           done,
    output logic           wrap,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BLW-1:0] rem_q, rem_d;
    logic           mem_req_q, mem_req_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;
    logic [AW-1:0]  bus_addr;

`ifdef MAR_TIMEOUT_EN
    localparam int              WW        = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
`endif

    // A wide bus keeps only its low AW bits; a narrow bus is zero-extended.
    if (DW >= AW) begin : g_bus_trunc
        assign bus_addr = bus_in[AW-1:0];
    end else begin : g_bus_ext
        assign bus_addr = {{(AW-DW){1'b0}}, bus_in};
    end

    // Next-state logic. Loads and inc are only honoured in IDLE; a load in
    // the same cycle as start still applies, so the burst begins at it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        mem_req_d = mem_req_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
`ifdef MAR_TIMEOUT_EN
        wait_d    = wait_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (ld_bus) begin
                    addr_d = bus_addr;
                end else if (ld_pc) begin
                    addr_d = pc_in;
                end else if (inc) begin
                    addr_d = addr_q + ADDR_ONE;
                    wrap_d = (addr_q == ADDR_MAX);
                end
                if (start) begin
                    state_d   = ACCESS;
                    rem_d     = burst_len;
                    mem_req_d = 1'b1;
`ifdef MAR_TIMEOUT_EN
                    wait_d    = '0;
`endif
                end
            end
            ACCESS: begin
                if (mem_ack) begin
`ifdef MAR_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (rem_q != '0) begin
                        addr_d = addr_q + ADDR_ONE;
                        wrap_d = (addr_q == ADDR_MAX);
                        rem_d  = rem_q - 1'b1;
                    end else begin
                        // Last beat: addr stays on the final beat's address.
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
`ifdef MAR_TIMEOUT_EN
                // wait_q counts unacked cycles already seen; this edge closes
                // the TIMEOUT-th one, so the burst is abandoned here.
                else if (wait_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    rem_d     = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef MAR_TIMEOUT_EN
            wait_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            mem_req_q <= mem_req_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
`ifdef MAR_TIMEOUT_EN
            wait_q    <= wait_d;
            err_q     <= err_d;
`endif
        end
    end

    assign addr    = addr_q;
    assign mem_req = mem_req_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign wrap    = wrap_q;
`ifdef MAR_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mar_burst.sv
// tb_mar_burst -- directed self-checking bench for mar_burst.
// Drives a linear sequence of hand-computed vectors and checks outputs 1ns
// after each rising edge. Timeout behaviour is checked according to whether
// MAR_TIMEOUT_EN is defined for the build.

module tb_mar_burst;

    logic       clk;
    logic       rst;
    logic       ld_pc;
    logic       ld_bus;
    logic       inc;
    logic [5:0] pc_in;
    logic [7:0] bus_in;
    logic       start;
    logic [2:0] burst_len;
    logic       mem_ack;
    logic [5:0] addr;
    logic       mem_req;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    int total = 0;
    int bad   = 0;

    mar_burst #(
        .AW(6), .DW(8), .BLW(3), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_pc(ld_pc), .ld_bus(ld_bus), .inc(inc),
        .pc_in(pc_in), .bus_in(bus_in),
        .start(start), .burst_len(burst_len), .mem_ack(mem_ack),
        .addr(addr), .mem_req(mem_req), .busy(busy),
        .done(done), .wrap(wrap), .err(err)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set every DUT input, then let one edge sample them.
    task automatic applyStimulus(input logic ldp, input logic ldb, input logic inc_i,
                                 input logic [5:0] pc, input logic [7:0] bus,
                                 input logic st, input logic [2:0] bl, input logic ack);
        ld_pc     = ldp;
        ld_bus    = ldb;
        inc       = inc_i;
        pc_in     = pc;
        bus_in    = bus;
        start     = st;
        burst_len = bl;
        mem_ack   = ack;
        tick();
    endtask

    // One comparison: count it, and report a failure with both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, loads, wrap, bursts, stalls, timeout.
    initial begin
        rst = 1'b1;
        ld_pc = 0; ld_bus = 0; inc = 0; pc_in = '0; bus_in = '0;
        start = 0; burst_len = '0; mem_ack = 0;
        #2 rst = 1'b0;
        tick();
        tick();
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_wrap", wrap, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b1;

        applyStimulus(1, 0, 0, 6'd12, 8'd0, 0, 3'd0, 0);
        checkOutput("ldpc_12", addr, 12);

        // ld_bus beats ld_pc
        applyStimulus(1, 1, 0, 6'd13, 8'd33, 0, 3'd0, 0);
        checkOutput("prio_bus", addr, 33);

        // Wide bus value truncated to 6 bits
        applyStimulus(0, 1, 0, 6'd0, 8'hC5, 0, 3'd0, 0);
        checkOutput("bus_trunc", addr, 6'h05);

        // Wrap from 63 to 0
        applyStimulus(1, 0, 0, 6'd63, 8'd0, 0, 3'd0, 0);
        checkOutput("ld_63", addr, 63);
        checkOutput("ld_63_wrap", wrap, 0);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("wrap_addr", addr, 0);
        checkOutput("wrap_pulse", wrap, 1);
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("wrap_clear", wrap, 0);
        checkOutput("wrap_hold", addr, 0);

        // Plain increment
        applyStimulus(1, 0, 0, 6'd10, 8'd0, 0, 3'd0, 0);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("inc_11", addr, 11);
        checkOutput("inc_nowrap", wrap, 0);

        // Burst of 4 with ack held, started with a same-cycle load of 20
        applyStimulus(1, 0, 0, 6'd20, 8'd0, 1, 3'd3, 1);
        checkOutput("b_req0", mem_req, 1);
        checkOutput("b_busy0", busy, 1);
        checkOutput("b_addr0", addr, 20);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("b_addr1", addr, 21);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("b_addr2", addr, 22);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("b_addr3", addr, 23);
        checkOutput("b_req3", mem_req, 1);
        checkOutput("b_done3", done, 0);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("b_done", done, 1);
        checkOutput("b_req_off", mem_req, 0);
        checkOutput("b_addr_keep", addr, 23);
        checkOutput("b_busy_done", busy, 1);
        applyStimulus(0, 0, 1, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("b_done_clr", done, 0);
        checkOutput("b_busy_clr", busy, 0);
        checkOutput("b_addr_end", addr, 23);

        // Two-beat burst at 40 with three stall cycles before each ack
        applyStimulus(1, 0, 0, 6'd40, 8'd0, 1, 3'd1, 0);
        checkOutput("s_addr0", addr, 40);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
            checkOutput("s_stall0_addr", addr, 40);
            checkOutput("s_stall0_req", mem_req, 1);
        end
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("s_addr1", addr, 41);
        checkOutput("s_req1", mem_req, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
            checkOutput("s_stall1_addr", addr, 41);
            checkOutput("s_stall1_req", mem_req, 1);
            checkOutput("s_stall1_done", done, 0);
        end
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 1);
        checkOutput("s_done", done, 1);
        checkOutput("s_req_off", mem_req, 0);
        checkOutput("s_addr_keep", addr, 41);
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("s_idle", busy, 0);

        // Asynchronous reset in the middle of a burst at 22
        applyStimulus(1, 0, 0, 6'd22, 8'd0, 1, 3'd7, 0);
        checkOutput("r_addr22", addr, 22);
        checkOutput("r_req", mem_req, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("r_async_addr", addr, 0);
        checkOutput("r_async_req", mem_req, 0);
        checkOutput("r_async_busy", busy, 0);
        #1 rst = 1'b1;
        applyStimulus(1, 0, 0, 6'd12, 8'd0, 0, 3'd0, 0);
        checkOutput("r_ldpc_12", addr, 12);
        checkOutput("r_req_idle", mem_req, 0);

        // Burst at 5 that never sees an ack
        applyStimulus(1, 0, 0, 6'd5, 8'd0, 1, 3'd0, 0);
        checkOutput("t_req0", mem_req, 1);
`ifdef MAR_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
            checkOutput("t_wait_req", mem_req, 1);
            checkOutput("t_wait_err", err, 0);
        end
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("t_err", err, 1);
        checkOutput("t_req_off", mem_req, 0);
        checkOutput("t_busy_off", busy, 0);
        checkOutput("t_addr", addr, 5);
        checkOutput("t_no_done", done, 0);
        applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
        checkOutput("t_err_clr", err, 0);
        checkOutput("t_no_done2", done, 0);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 0, 6'd0, 8'd0, 0, 3'd0, 0);
        end
        checkOutput("t_req_held", mem_req, 1);
        checkOutput("t_busy_held", busy, 1);
        checkOutput("t_addr_held", addr, 5);
        checkOutput("t_err_zero", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
